// File: rtl/v3_free_list_pkg.sv
// Shared types and helpers for the tag free-list controller.
package v3_free_list_pkg;

    // Controller modes: normal allocate/return traffic, or re-seeding the list.
    typedef enum logic {
        READY  = 1'b0,
        REINIT = 1'b1
    } fl_state_e;

    // Advance a circular pointer, wrapping from num-1 back to 0. The pool size
    // need not be a power of two, so the wrap is an explicit compare.
    function automatic int ptr_inc(input int ptr, input int num);
        return (ptr == num - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/v3_Mem1r1w.sv
// One-read/one-write register-file memory. Combinational read, synchronous
// write; synchronous reset loads each entry with its own index.
module v3_Mem1r1w #(
    parameter int p_num_entries = 8,
    parameter int p_bit_width   = 8,
    parameter int p_addr_width  = $clog2(p_num_entries)
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_read_en,
    input  logic [p_addr_width-1:0] i_read_addr,
    output logic [p_bit_width-1:0]  o_read_data,
    input  logic                    i_write_en,
    input  logic [p_addr_width-1:0] i_write_addr,
    input  logic [p_bit_width-1:0]  i_write_data
);

    logic [p_bit_width-1:0] r_mem [p_num_entries];

    // Storage update: reset seeds the identity pattern, otherwise one write per cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < p_num_entries; i++) begin
                r_mem[i] <= p_bit_width'(i);
            end
        end else if (i_write_en) begin
            r_mem[i_write_addr] <= i_write_data;
        end
    end

    assign o_read_data = i_read_en ? r_mem[i_read_addr] : '0;

endmodule

// File: rtl/v3_free_list_ctrl.sv
// Circular free list of tags (ROB slots / physical registers). Hands out the
// tag at the head and accepts returned tags at the tail, one of each per
// cycle. A flush walks the storage back to the identity order 0..N-1.
module v3_free_list_ctrl #(
    parameter int p_num_entries = 8,
    parameter int p_tag_width   = $clog2(p_num_entries),
    parameter int p_cnt_width   = $clog2(p_num_entries + 1)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic                   alloc_val,
    output logic                   alloc_rdy,
    output logic [p_tag_width-1:0] alloc_tag,
    input  logic                   free_val,
    output logic                   free_rdy,
    input  logic [p_tag_width-1:0] free_tag,
    output logic [p_cnt_width-1:0] free_count,
    output logic                   reinit_busy
);

    import v3_free_list_pkg::*;

    localparam logic [p_tag_width-1:0] LP_LAST = p_tag_width'(p_num_entries - 1);
    localparam logic [p_cnt_width-1:0] LP_FULL = p_cnt_width'(p_num_entries);

    fl_state_e              r_state;
    fl_state_e              w_state_nxt;
    logic [p_tag_width-1:0] r_head;
    logic [p_tag_width-1:0] r_tail;
    logic [p_tag_width-1:0] r_init_idx;
    logic [p_cnt_width-1:0] r_count;
    logic [p_tag_width-1:0] w_head_nxt;
    logic [p_tag_width-1:0] w_tail_nxt;
    logic [p_tag_width-1:0] w_init_idx_nxt;
    logic [p_cnt_width-1:0] w_count_nxt;

    logic                   w_ready;
    logic                   w_alloc_fire;
    logic                   w_free_fire;
    logic                   w_mem_we;
    logic [p_tag_width-1:0] w_mem_waddr;
    logic [p_tag_width-1:0] w_mem_wdata;
    logic [p_tag_width-1:0] w_mem_rdata;

    // Handshakes are closed during reset, re-init and the flush cycle itself;
    // there is no free->alloc bypass when the list is empty.
    assign w_ready      = (r_state == READY);
    assign alloc_rdy    = reset_n & w_ready & ~flush & (r_count != '0);
    assign free_rdy     = reset_n & w_ready & ~flush & (r_count != LP_FULL);
    assign reinit_busy  = reset_n & (r_state == REINIT);
    assign w_alloc_fire = alloc_val & alloc_rdy;
    assign w_free_fire  = free_val & free_rdy;
    assign alloc_tag    = w_mem_rdata;
    assign free_count   = r_count;

    // Write port: the init walk owns it during REINIT, the return path otherwise.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_waddr = r_tail;
        w_mem_wdata = free_tag;
        if (r_state == REINIT) begin
            w_mem_we    = 1'b1;
            w_mem_waddr = r_init_idx;
            w_mem_wdata = r_init_idx;
        end else if (w_free_fire) begin
            w_mem_we    = 1'b1;
        end
    end

    v3_Mem1r1w #(
        .p_num_entries (p_num_entries),
        .p_bit_width   (p_tag_width)
    ) u_mem (
        .i_clk        (clk),
        .i_reset      (~reset_n),
        .i_read_en    (1'b1),
        .i_read_addr  (r_head),
        .o_read_data  (w_mem_rdata),
        .i_write_en   (w_mem_we),
        .i_write_addr (w_mem_waddr),
        .i_write_data (w_mem_wdata)
    );

    // Next-state logic for the mode FSM, pointers, count and init walk.
    always_comb begin
        w_state_nxt    = r_state;
        w_head_nxt     = r_head;
        w_tail_nxt     = r_tail;
        w_count_nxt    = r_count;
        w_init_idx_nxt = r_init_idx;
        unique case (r_state)
            READY: begin
                if (flush) begin
                    w_state_nxt    = REINIT;
                    w_init_idx_nxt = '0;
                end else begin
                    if (w_alloc_fire) begin
                        w_head_nxt = p_tag_width'(ptr_inc(int'(r_head), p_num_entries));
                    end
                    if (w_free_fire) begin
                        w_tail_nxt = p_tag_width'(ptr_inc(int'(r_tail), p_num_entries));
                    end
                    unique case ({w_alloc_fire, w_free_fire})
                        2'b10:   w_count_nxt = r_count - p_cnt_width'(1);
                        2'b01:   w_count_nxt = r_count + p_cnt_width'(1);
                        default: w_count_nxt = r_count;
                    endcase
                end
            end
            REINIT: begin
                if (flush) begin
                    // A flush during re-init restarts the walk from entry 0.
                    w_init_idx_nxt = '0;
                end else if (r_init_idx == LP_LAST) begin
                    w_state_nxt    = READY;
                    w_head_nxt     = '0;
                    w_tail_nxt     = '0;
                    w_count_nxt    = LP_FULL;
                    w_init_idx_nxt = '0;
                end else begin
                    w_init_idx_nxt = p_tag_width'(ptr_inc(int'(r_init_idx), p_num_entries));
                end
            end
            default: begin
                w_state_nxt = READY;
            end
        endcase
    end

    // State register with synchronous active-low reset to a full identity list.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= READY;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= LP_FULL;
            r_init_idx <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_head     <= w_head_nxt;
            r_tail     <= w_tail_nxt;
            r_count    <= w_count_nxt;
            r_init_idx <= w_init_idx_nxt;
        end
    end

endmodule

// File: tb/tb_v3_free_list_ctrl.sv
// Bench for v3_free_list_ctrl: an 8-entry and a 6-entry instance, directed
// stimulus, expected allocation tags queued per instance and checked by
// independent monitors whenever an allocation handshake completes.
module tb_v3_free_list_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;

    logic       flush8, av8, ar8, fv8, fr8, busy8;
    logic [2:0] at8, ft8;
    logic [3:0] cnt8;

    logic       flush6, av6, ar6, fv6, fr6, busy6;
    logic [2:0] at6, ft6;
    logic [2:0] cnt6;

    int n_vec = 0;
    int n_bad = 0;

    int m8[$];
    int exp8[$];
    int m6[$];
    int exp6[$];
    bit set8 [8];
    bit set6 [6];
    int last_a8;
    int last_a6;
    int oq[$];

    v3_free_list_ctrl #(.p_num_entries(8)) dut8 (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush       (flush8),
        .alloc_val   (av8),
        .alloc_rdy   (ar8),
        .alloc_tag   (at8),
        .free_val    (fv8),
        .free_rdy    (fr8),
        .free_tag    (ft8),
        .free_count  (cnt8),
        .reinit_busy (busy8)
    );

    v3_free_list_ctrl #(.p_num_entries(6)) dut6 (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush       (flush6),
        .alloc_val   (av6),
        .alloc_rdy   (ar6),
        .alloc_tag   (at6),
        .free_val    (fv6),
        .free_rdy    (fr6),
        .free_tag    (ft6),
        .free_count  (cnt6),
        .reinit_busy (busy6)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic reset_model8();
        m8 = {};
        for (int i = 0; i < 8; i++) begin
            m8.push_back(i);
            set8[i] = 1'b0;
        end
    endtask

    task automatic reset_model6();
        m6 = {};
        for (int i = 0; i < 6; i++) begin
            m6.push_back(i);
            set6[i] = 1'b0;
        end
    endtask

    // a/f: 0 = idle, 1 = drive and expect fire, 2 = drive but expect no fire.
    // lit >= 0 overrides the model with a hand-computed expected tag.
    task automatic step8(input int a, input int f, input int t, input bit fl, input int lit);
        int tg;
        @(posedge clk);
        #1;
        av8    = (a != 0);
        fv8    = (f != 0);
        ft8    = 3'(t);
        flush8 = fl;
        if (a == 1) begin
            tg = m8.pop_front();
            set8[tg] = 1'b1;
            last_a8 = tg;
            exp8.push_back((lit >= 0) ? lit : tg);
        end
        if (f == 1) begin
            assert (set8[t]) else $error("illegal free of tag %0d on 8-entry list", t);
            set8[t] = 1'b0;
            m8.push_back(t);
        end
        @(negedge clk);
    endtask

    task automatic step6(input int a, input int f, input int t, input int lit);
        int tg;
        @(posedge clk);
        #1;
        av6    = (a != 0);
        fv6    = (f != 0);
        ft6    = 3'(t);
        flush6 = 1'b0;
        if (a == 1) begin
            tg = m6.pop_front();
            set6[tg] = 1'b1;
            last_a6 = tg;
            exp6.push_back((lit >= 0) ? lit : tg);
        end
        if (f == 1) begin
            assert (set6[t]) else $error("illegal free of tag %0d on 6-entry list", t);
            set6[t] = 1'b0;
            m6.push_back(t);
        end
        @(negedge clk);
    endtask

    // Monitor for the 8-entry list: every completed allocation consumes one expectation.
    always @(negedge clk) begin
        if (reset_n && av8 && ar8) begin
            if (exp8.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL alloc8_spurious: tag %0d handed out, required no allocation", at8);
            end else begin
                chk("alloc8_tag", int'(at8), exp8.pop_front());
            end
        end
    end

    // Monitor for the 6-entry list.
    always @(negedge clk) begin
        if (reset_n && av6 && ar6) begin
            if (exp6.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL alloc6_spurious: tag %0d handed out, required no allocation", at6);
            end else begin
                chk("alloc6_tag", int'(at6), exp6.pop_front());
            end
        end
    end

    // Bound the run in case the stimulus thread stalls.
    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, required end of stimulus");
        $fatal(1, "watchdog expired");
    end

    // Directed stimulus.
    initial begin
        int t;
        reset_n = 1'b0;
        flush8 = 1'b0; av8 = 1'b1; fv8 = 1'b0; ft8 = '0;
        flush6 = 1'b0; av6 = 1'b0; fv6 = 1'b0; ft6 = '0;
        reset_model8();
        reset_model6();

        // Reset: handshakes closed while reset_n is low.
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst_alloc_rdy", int'(ar8), 0);
        chk("rst_free_rdy", int'(fr8), 0);
        chk("rst_busy", int'(busy8), 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        av8 = 1'b0;
        @(negedge clk);
        chk("post_rst_alloc_rdy", int'(ar8), 1);
        chk("post_rst_alloc_tag", int'(at8), 0);
        chk("post_rst_count", int'(cnt8), 8);
        chk("post_rst_free_rdy_full", int'(fr8), 0);

        // 1: drain the full list in identity order.
        for (int k = 0; k < 8; k++) begin
            step8(1, 0, 0, 1'b0, k);
            chk("t1_count", int'(cnt8), 8 - k);
        end
        step8(2, 0, 0, 1'b0, -1);
        chk("t1_empty_alloc_rdy", int'(ar8), 0);
        chk("t1_empty_count", int'(cnt8), 0);
        chk("t1_empty_free_rdy", int'(fr8), 1);

        // 2: returned tags come back out in return order.
        step8(0, 1, 5, 1'b0, -1);
        step8(0, 1, 2, 1'b0, -1);
        step8(0, 1, 7, 1'b0, -1);
        step8(1, 0, 0, 1'b0, 5);
        chk("t2_count_a", int'(cnt8), 3);
        step8(1, 0, 0, 1'b0, 2);
        chk("t2_count_b", int'(cnt8), 2);
        step8(1, 0, 0, 1'b0, 7);
        chk("t2_count_c", int'(cnt8), 1);

        // 3: empty list, simultaneous request and return: no bypass.
        step8(2, 1, 3, 1'b0, -1);
        chk("t3_alloc_rdy_empty", int'(ar8), 0);
        chk("t3_free_rdy", int'(fr8), 1);
        chk("t3_count", int'(cnt8), 0);
        step8(1, 0, 0, 1'b0, 3);
        chk("t3_next_alloc_rdy", int'(ar8), 1);
        chk("t3_next_count", int'(cnt8), 1);

        // 4: four free tags, then 20 cycles of concurrent alloc+free.
        step8(0, 1, 0, 1'b0, -1);
        step8(0, 1, 1, 1'b0, -1);
        step8(0, 1, 4, 1'b0, -1);
        step8(0, 1, 6, 1'b0, -1);
        oq = {2, 3, 5, 7};
        for (int i = 0; i < 20; i++) begin
            t = oq.pop_front();
            step8(1, 1, t, 1'b0, -1);
            oq.push_back(last_a8);
            chk("t4_count_steady", int'(cnt8), 4);
        end

        // 5: flush mid-traffic; requests in the flush cycle must not fire.
        t = oq[0];
        step8(2, 2, t, 1'b1, -1);
        reset_model8();
        chk("t5_flush_alloc_rdy", int'(ar8), 0);
        chk("t5_flush_free_rdy", int'(fr8), 0);
        chk("t5_flush_count", int'(cnt8), 4);
        for (int i = 0; i < 8; i++) begin
            step8(2, 2, t, 1'b0, -1);
            chk("t5_busy", int'(busy8), 1);
            chk("t5_alloc_rdy", int'(ar8), 0);
            chk("t5_free_rdy", int'(fr8), 0);
            chk("t5_count_hold", int'(cnt8), 4);
        end
        for (int k = 0; k < 8; k++) begin
            step8(1, 0, 0, 1'b0, k);
            chk("t5_post_count", int'(cnt8), 8 - k);
            chk("t5_post_busy", int'(busy8), 0);
        end
        // Second flush, re-flushed on the third re-init cycle.
        step8(0, 0, 0, 1'b1, -1);
        reset_model8();
        step8(0, 0, 0, 1'b0, -1);
        chk("t5b_busy_1", int'(busy8), 1);
        step8(0, 0, 0, 1'b0, -1);
        chk("t5b_busy_2", int'(busy8), 1);
        step8(0, 0, 0, 1'b1, -1);
        chk("t5b_busy_3", int'(busy8), 1);
        chk("t5b_count_hold", int'(cnt8), 0);
        for (int i = 0; i < 8; i++) begin
            step8(0, 0, 0, 1'b0, -1);
            chk("t5b_busy_more", int'(busy8), 1);
        end
        step8(1, 0, 0, 1'b0, 0);
        chk("t5b_exit_busy", int'(busy8), 0);
        chk("t5b_exit_count", int'(cnt8), 8);

        // 6: reset during re-init returns straight to a full list.
        step8(0, 0, 0, 1'b1, -1);
        step8(0, 0, 0, 1'b0, -1);
        step8(0, 0, 0, 1'b0, -1);
        chk("t6_busy_before_rst", int'(busy8), 1);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(negedge clk);
        chk("t6_rst_busy", int'(busy8), 0);
        chk("t6_rst_alloc_rdy", int'(ar8), 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        reset_model8();
        reset_model6();
        @(negedge clk);
        chk("t6_after_busy", int'(busy8), 0);
        chk("t6_after_alloc_tag", int'(at8), 0);
        chk("t6_after_count", int'(cnt8), 8);
        step8(1, 0, 0, 1'b0, 0);
        step8(0, 0, 0, 1'b0, -1);
        chk("t6_count_after_alloc", int'(cnt8), 7);

        // N=6: non-power-of-two wrap of head and tail.
        step6(0, 0, 0, -1);
        chk("n6_free_rdy_full", int'(fr6), 0);
        chk("n6_count_full", int'(cnt6), 6);
        for (int k = 0; k < 6; k++) begin
            step6(1, 0, 0, k);
            chk("n6_count", int'(cnt6), 6 - k);
        end
        step6(2, 0, 0, -1);
        chk("n6_empty_alloc_rdy", int'(ar6), 0);
        step6(0, 1, 0, -1);
        step6(0, 1, 1, -1);
        oq = {2, 3, 4, 5};
        for (int i = 0; i < 14; i++) begin
            t = oq.pop_front();
            step6(1, 1, t, -1);
            oq.push_back(last_a6);
            chk("n6_count_steady", int'(cnt6), 2);
        end
        step6(0, 0, 0, -1);
        chk("n6_final_count", int'(cnt6), 2);

        chk("exp8_drained", exp8.size(), 0);
        chk("exp6_drained", exp6.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
